// File: rtl/coef_ram_loader.sv
// coef_ram_loader
//   Turns SPI coefficient strobes into writes on the shared coefficient RAM.
//   Each strobe assembles {coef_msb, coef_lsb} and computes the address
//   filter_sel*MAX_TAPS + tap_idx. The tap index advances after every accepted
//   write. Accepted writes wait in a small FIFO. The single RAM port goes to
//   the FIR engine while it is reading. After STARVE_LIMIT consecutive blocked
//   cycles, the head write is forced and the FIR read is stalled for one cycle.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   coef_wr_stb       one-cycle strobe: coefficient bytes are complete
//   coef_lsb/msb      coefficient bits [7:0] / [15:8]
//   filter_sel        target filter
//   taps_per_filter   active taps per filter (0 means 256)
//   tap_restart       return the tap index to 0
//   err_clear         clear the sticky error flags
//   fir_rd_en/addr    FIR engine read request and address
//   fir_rd_stall      FIR read not serviced this cycle
//   ram_en/we/addr/wdata  RAM port
//   tap_idx           next tap index to be written
//   busy              pending writes in the FIFO
//   wrap_pulse        tap index wrapped to 0 on the previous push
//   overflow_err      sticky: strobe arrived with the FIFO full
//   range_err         sticky: strobe arrived with filter_sel out of range
module coef_ram_loader #(
    parameter int unsigned NUM_FILTERS  = 4,
    parameter int unsigned MAX_TAPS     = 256,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 15,
    parameter int unsigned ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              coef_wr_stb,
    input  logic [7:0]        coef_lsb,
    input  logic [7:0]        coef_msb,
    input  logic [7:0]        filter_sel,
    input  logic [7:0]        taps_per_filter,
    input  logic              tap_restart,
    input  logic              err_clear,
    input  logic              fir_rd_en,
    input  logic [ADDR_W-1:0] fir_rd_addr,
    output logic              fir_rd_stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic [7:0]        tap_idx,
    output logic              busy,
    output logic              wrap_pulse,
    output logic              overflow_err,
    output logic              range_err
);

    localparam int unsigned TapW  = $clog2(MAX_TAPS);
    localparam int unsigned FselW = ADDR_W - TapW;
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned StW   = $clog2(STARVE_LIMIT + 1);

    localparam logic [7:0]      TapMask   = 8'(MAX_TAPS - 1);
    localparam logic [CntW-1:0] FifoFull  = CntW'(FIFO_DEPTH);
    localparam logic [StW-1:0]  StarveMax = StW'(STARVE_LIMIT);

    typedef enum logic [0:0] {StIdle, StPend} state_e;

    state_e state_q, state_d;

    logic [7:0]        tap_idx_q, tap_idx_d;
    logic              wrap_q, wrap_d;
    logic              ovf_q, ovf_d;
    logic              rng_q, rng_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [StW-1:0]    starve_q, starve_d;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [15:0]       fifo_data_q [FIFO_DEPTH];

    logic              range_hit, fifo_full, ovf_hit, push, pop, tap_wrap;
    logic [7:0]        tap_last;
    logic [ADDR_W-1:0] push_addr;

    // ------------------------------------------------------------------
    // Capture: validate the strobe and compute the target address
    // ------------------------------------------------------------------
    always_comb begin
        range_hit = coef_wr_stb && (32'(filter_sel) >= NUM_FILTERS);
        // Fullness is judged before any pop this cycle, so a full FIFO
        // rejects the strobe even while it is draining.
        fifo_full = (cnt_q == FifoFull);
        ovf_hit   = coef_wr_stb && !range_hit && fifo_full;
        push      = coef_wr_stb && !range_hit && !fifo_full;
        tap_last  = ((taps_per_filter == 8'd0) ? 8'hFF : taps_per_filter - 8'd1) & TapMask;
        tap_wrap  = (tap_idx_q == tap_last);
        push_addr = {filter_sel[FselW-1:0], tap_idx_q[TapW-1:0]};
    end

    always_comb begin
        tap_idx_d = tap_idx_q;
        wrap_d    = 1'b0;
        if (push) begin
            tap_idx_d = tap_wrap ? 8'd0 : tap_idx_q + 8'd1;
            wrap_d    = tap_wrap;
        end
        // Restart wins over the increment and suppresses the wrap pulse.
        if (tap_restart) begin
            tap_idx_d = 8'd0;
            wrap_d    = 1'b0;
        end
        ovf_d = ovf_hit | (ovf_q & ~err_clear);
        rng_d = range_hit | (rng_q & ~err_clear);
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping and starvation counter
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
        // In PEND without a pop, the FIR read must have won the port.
        if (pop || (state_q == StIdle)) begin
            starve_d = '0;
        end else begin
            starve_d = starve_q + StW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= push_addr;
            fifo_data_q[wr_ptr_q] <= {coef_msb, coef_lsb};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tap_idx_q <= '0;
            wrap_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rng_q     <= 1'b0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            starve_q  <= '0;
        end else begin
            tap_idx_q <= tap_idx_d;
            wrap_q    <= wrap_d;
            ovf_q     <= ovf_d;
            rng_q     <= rng_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            starve_q  <= starve_d;
        end
    end

    // ------------------------------------------------------------------
    // Arbiter FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = (cnt_d != '0) ? StPend : StIdle;
    end

    always_comb begin
        pop          = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        fir_rd_stall = 1'b0;
        // Reset blocks the port so that no pending write leaks out.
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    ram_en   = fir_rd_en;
                    ram_addr = fir_rd_addr;
                end
                StPend: begin
                    if (!fir_rd_en || (starve_q == StarveMax)) begin
                        pop          = 1'b1;
                        ram_en       = 1'b1;
                        ram_we       = 1'b1;
                        ram_addr     = fifo_addr_q[rd_ptr_q];
                        ram_wdata    = fifo_data_q[rd_ptr_q];
                        fir_rd_stall = fir_rd_en;
                    end else begin
                        ram_en   = 1'b1;
                        ram_addr = fir_rd_addr;
                    end
                end
                default: begin
                    pop = 1'b0;
                end
            endcase
        end
    end

    assign tap_idx      = tap_idx_q;
    assign busy         = (cnt_q != '0);
    assign wrap_pulse   = wrap_q;
    assign overflow_err = ovf_q;
    assign range_err    = rng_q;

endmodule

// File: tb/tb_coef_ram_loader.sv
module tb_coef_ram_loader;

    localparam int NF = 4;
    localparam int MT = 256;
    localparam int FD = 4;
    localparam int SL = 15;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          coef_wr_stb;
    logic [7:0]    coef_lsb, coef_msb, filter_sel, taps_per_filter;
    logic          tap_restart, err_clear, fir_rd_en;
    logic [AW-1:0] fir_rd_addr;
    logic          fir_rd_stall, ram_en, ram_we, busy, wrap_pulse, overflow_err, range_err;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata;
    logic [7:0]    tap_idx;

    coef_ram_loader #(
        .NUM_FILTERS(NF), .MAX_TAPS(MT), .FIFO_DEPTH(FD), .STARVE_LIMIT(SL), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .coef_wr_stb(coef_wr_stb), .coef_lsb(coef_lsb),
        .coef_msb(coef_msb), .filter_sel(filter_sel), .taps_per_filter(taps_per_filter),
        .tap_restart(tap_restart), .err_clear(err_clear), .fir_rd_en(fir_rd_en),
        .fir_rd_addr(fir_rd_addr), .fir_rd_stall(fir_rd_stall), .ram_en(ram_en),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .tap_idx(tap_idx),
        .busy(busy), .wrap_pulse(wrap_pulse), .overflow_err(overflow_err),
        .range_err(range_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: a queue of pending writes and a tap counter.
    typedef struct {int addr; int data;} wr_t;
    wr_t m_q[$];
    wr_t wlog[$];
    int  m_tap, m_blocked, m_last, m_pre;
    bit  m_wrap, m_ovf, m_rng, m_valid = 0;

    always @(negedge clk) begin
        if (!reset && ram_en && ram_we) wlog.push_back('{int'(ram_addr), int'(ram_wdata)});
        if (reset) begin
            chk("rst_ram_en", ram_en, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_stall", fir_rd_stall, 0);
            m_q.delete();
            m_tap = 0; m_blocked = 0; m_wrap = 0; m_ovf = 0; m_rng = 0; m_valid = 1;
        end else if (m_valid) begin
            m_pre = m_q.size();
            chk("m_busy", busy, int'(m_pre != 0));
            chk("m_tap_idx", tap_idx, m_tap);
            chk("m_wrap", wrap_pulse, m_wrap);
            chk("m_ovf", overflow_err, m_ovf);
            chk("m_rng", range_err, m_rng);
            if (m_pre == 0) begin
                chk("m_idle_en", ram_en, fir_rd_en);
                chk("m_idle_we", ram_we, 0);
                chk("m_idle_stall", fir_rd_stall, 0);
                if (fir_rd_en) chk("m_idle_addr", ram_addr, fir_rd_addr);
            end else if (!fir_rd_en || m_blocked == SL) begin
                chk("m_wr_en", ram_en, 1);
                chk("m_wr_we", ram_we, 1);
                chk("m_wr_stall", fir_rd_stall, fir_rd_en);
                chk("m_wr_addr", ram_addr, m_q[0].addr);
                chk("m_wr_data", ram_wdata, m_q[0].data);
                void'(m_q.pop_front());
                m_blocked = 0;
            end else begin
                chk("m_rd_en", ram_en, 1);
                chk("m_rd_we", ram_we, 0);
                chk("m_rd_stall", fir_rd_stall, 0);
                chk("m_rd_addr", ram_addr, fir_rd_addr);
                m_blocked++;
            end
            m_wrap = 0;
            if (err_clear) begin
                m_ovf = 0;
                m_rng = 0;
            end
            if (coef_wr_stb) begin
                if (int'(filter_sel) >= NF) m_rng = 1;
                else if (m_pre == FD) m_ovf = 1;
                else begin
                    m_q.push_back('{int'(filter_sel) * MT + m_tap,
                                    int'(coef_msb) * 256 + int'(coef_lsb)});
                    m_last = ((taps_per_filter == 0) ? 256 : int'(taps_per_filter)) - 1;
                    m_last = m_last % MT;
                    if (m_tap == m_last) begin
                        m_tap  = 0;
                        m_wrap = 1;
                    end else m_tap++;
                end
            end
            if (tap_restart) begin
                m_tap  = 0;
                m_wrap = 0;
            end
            if (m_q.size() == 0) m_blocked = 0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] msb, input logic [7:0] lsb);
        coef_wr_stb = 1'b1;
        coef_msb    = msb;
        coef_lsb    = lsb;
        cyc();
        coef_wr_stb = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected done by 100000");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; coef_wr_stb = 0; coef_lsb = 0; coef_msb = 0; filter_sel = 0;
        taps_per_filter = 0; tap_restart = 0; err_clear = 0; fir_rd_en = 0; fir_rd_addr = 0;
        cyc(); cyc();
        reset = 0;
        chk("reset_tap", tap_idx, 0);
        chk("reset_busy", busy, 0);
        cyc();

        // Four strobes into filter 2, four taps per filter
        filter_sel = 8'd2; taps_per_filter = 8'd4;
        for (int i = 0; i < 4; i++) strobe(8'(17 * (i + 1)), 8'(17 * (i + 1)));
        chk("t1_wrap_pulse", wrap_pulse, 1);
        chk("t1_tap_idx", tap_idx, 0);
        cyc(); cyc();
        chk("t1_nwrites", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            chk("t1_addr", wlog[i].addr, 512 + i);
            chk("t1_data", wlog[i].data, 'h1111 * (i + 1));
        end

        // Fifth strobe lands on the wrapped index
        strobe(8'h55, 8'h55);
        chk("t2_we", ram_we, 1);
        chk("t2_addr", ram_addr, 512);
        chk("t2_data", ram_wdata, 'h5555);
        cyc();

        // Starvation guard with the FIR reading continuously
        fir_rd_en = 1; fir_rd_addr = 10'd100;
        strobe(8'h66, 8'h66);
        for (int k = 0; k < 15; k++) begin
            chk("t3_read_serviced", {ram_en, ram_we, fir_rd_stall}, 3'b100);
            cyc();
        end
        chk("t3_forced_we", ram_we, 1);
        chk("t3_forced_stall", fir_rd_stall, 1);
        chk("t3_forced_addr", ram_addr, 513);
        cyc();
        chk("t3_resume", {ram_en, ram_we, fir_rd_stall, busy}, 4'b1000);

        // Overflow with five back-to-back strobes while the FIR holds the port
        filter_sel = 8'd1; taps_per_filter = 8'd0;
        tap_restart = 1; cyc(); tap_restart = 0;
        for (int i = 0; i < 5; i++) strobe(8'hA0, 8'(i));
        chk("t4_ovf", overflow_err, 1);
        chk("t4_tap_idx", tap_idx, 4);
        chk("t4_busy", busy, 1);
        err_clear = 1; cyc(); err_clear = 0;
        chk("t4_ovf_cleared", overflow_err, 0);
        wlog.delete();
        fir_rd_en = 0;
        repeat (5) cyc();
        chk("t4_drained", busy, 0);
        chk("t4_nwrites", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            chk("t4_addr", wlog[i].addr, 256 + i);
            chk("t4_data", wlog[i].data, 'hA000 + i);
        end

        // Out-of-range filter
        filter_sel = 8'd7;
        strobe(8'h12, 8'h34);
        chk("t5_rng", range_err, 1);
        chk("t5_tap_idx", tap_idx, 4);
        chk("t5_no_write", ram_we, 0);
        chk("t5_not_busy", busy, 0);
        err_clear = 1; cyc(); err_clear = 0;
        chk("t5_rng_cleared", range_err, 0);

        // Restart coinciding with a strobe at tap 3
        filter_sel = 8'd0;
        tap_restart = 1; cyc(); tap_restart = 0;
        for (int i = 0; i < 3; i++) strobe(8'h00, 8'(i + 1));
        tap_restart = 1;
        strobe(8'h0B, 8'hEE);
        tap_restart = 0;
        chk("t6_tap_idx", tap_idx, 0);
        chk("t6_no_wrap", wrap_pulse, 0);
        chk("t6_we", ram_we, 1);
        chk("t6_addr", ram_addr, 3);
        chk("t6_data", ram_wdata, 'h0BEE);
        cyc();

        // Reset with two writes pending
        fir_rd_en = 1;
        strobe(8'hC0, 8'h01);
        strobe(8'hC0, 8'h02);
        chk("t7_busy_before", busy, 1);
        reset = 1; fir_rd_en = 0;
        chk("t7_we_in_reset", ram_we, 0);
        cyc();
        reset = 0;
        wlog.delete();
        chk("t7_busy_after", busy, 0);
        repeat (3) cyc();
        chk("t7_no_writes", wlog.size(), 0);
        chk("t7_tap_idx", tap_idx, 0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/coef_ram_loader.md
Name: coef_ram_loader

Overview:
- Sequences SPI-originated FIR coefficient writes into the shared coefficient RAM.
- Assembles the 16-bit coefficient from the LSB/MSB registers and computes the RAM address as filter*MAX_TAPS + tap index.
- Auto-increments the tap index after each write.
- Arbitrates the single RAM port between the FIR engine (reads, normal priority) and the loader (writes), buffering pending writes in a small FIFO with a starvation guard.

Parameters:
- NUM_FILTERS, 4, number of filters; valid filter_sel range is 0..NUM_FILTERS-1.
- MAX_TAPS, 256, tap slots per filter in RAM; must be a power of 2 and no more than 256.
- FIFO_DEPTH, 4, number of pending-write entries; must be a power of 2.
- STARVE_LIMIT, 15, number of consecutive blocked cycles after which a write is forced.
- ADDR_W, 10, RAM address width; must equal log2(NUM_FILTERS*MAX_TAPS).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- coef_wr_stb  in  1  one-cycle pulse: {coef_msb, coef_lsb} is a complete coefficient.
- coef_lsb  in  8  coefficient bits [7:0].
- coef_msb  in  8  coefficient bits [15:8].
- filter_sel  in  8  target filter.
- taps_per_filter  in  8  active taps per filter; 0 means 256.
- tap_restart  in  1  pulse: tap index returns to 0 (driven on a FILTER_SEL write).
- err_clear  in  1  pulse: clears the sticky error flags.
- fir_rd_en  in  1  FIR engine read request for this cycle.
- fir_rd_addr  in  ADDR_W  FIR read address.
- fir_rd_stall  out  1  FIR read not serviced this cycle; the engine must retry.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  16  RAM write data.
- tap_idx  out  8  next tap index to be written.
- busy  out  1  FIFO not empty.
- wrap_pulse  out  1  one-cycle pulse when the tap index wraps to 0.
- overflow_err  out  1  sticky: a strobe arrived with the FIFO full.
- range_err  out  1  sticky: a strobe arrived with filter_sel >= NUM_FILTERS.

Behaviour:
- Reset values:
  - All outputs 0.
  - tap_idx = 0, FIFO empty, starvation counter 0.
  - All state is synchronous to clk.
  - Reset during a pending write discards the FIFO contents; no RAM write occurs in the reset cycle or after it.
- Capture (cycle N, coef_wr_stb=1):
  - If filter_sel >= NUM_FILTERS: set range_err, drop the write, tap_idx unchanged.
  - Else if the FIFO is full: set overflow_err, drop the write, tap_idx unchanged. A pop in the same cycle does not free the entry for this strobe.
  - Else: push {addr = filter_sel*MAX_TAPS + tap_idx, data = {coef_msb, coef_lsb}}.
  - On push, tap_idx advances: tap_idx+1, or 0 when tap_idx == (taps_per_filter==0 ? 255 : taps_per_filter-1).
  - wrap_pulse is asserted in cycle N+1 when the index wraps.
  - The taps_per_filter index is applied modulo MAX_TAPS (low log2(MAX_TAPS) bits).
- tap_restart:
  - Forces tap_idx to 0 the next cycle.
  - If it coincides with coef_wr_stb, the push uses the old tap_idx, then tap_idx becomes 0. Restart wins over increment. No wrap_pulse.
- Arbiter states:
  - IDLE (FIFO empty): ram_addr = fir_rd_addr, ram_en = fir_rd_en, ram_we = 0, fir_rd_stall = 0.
  - PEND (FIFO non-empty), fir_rd_en = 0: pop the head and drive ram_en = ram_we = 1 with head addr/data in the same cycle.
  - PEND, fir_rd_en = 1 and counter < STARVE_LIMIT: service the FIR read, counter+1.
  - PEND, counter == STARVE_LIMIT: force the write, assert fir_rd_stall = 1 for that cycle, counter = 0.
  - The counter resets to 0 on every pop and on entering IDLE.
- Outputs are combinational from registered state and the FIR inputs.
- Minimum strobe-to-RAM-write latency is 1 cycle: push at N, write at N+1 when the FIR is idle.
- One write per cycle maximum. Writes are issued in FIFO order.
- busy = FIFO non-empty. Simultaneous push and pop while full is a pop only; the push is rejected as overflow.
- Error flags:
  - overflow_err and range_err stay set until err_clear.
  - If err_clear and a new error arrive in the same cycle, the flag stays set.

Test Plan:
- Reset, filter_sel=2, taps=4, four strobes with data 0x1111..0x4444, fir_rd_en=0 -> RAM writes to addr 512,513,514,515 with matching data. wrap_pulse one cycle after the 4th strobe. tap_idx=0.
- A fifth strobe after the above, data 0x5555 -> write to addr 512 (index wrapped).
- fir_rd_en held 1 with 1 write pending, STARVE_LIMIT=15 -> 15 FIR reads serviced, 16th cycle ram_we=1 with fir_rd_stall=1, then FIR resumes.
- 5 back-to-back strobes with fir_rd_en=1 -> 4 pushed, 5th sets overflow_err, tap_idx=4. err_clear -> overflow_err=0.
- filter_sel=7 strobe -> range_err=1, no RAM write, tap_idx unchanged.
- tap_restart together with a strobe at tap_idx=3 -> write at idx 3, then tap_idx=0. Reset asserted with 2 pending writes -> no further ram_we, busy=0.
